// File: rtl/memlcd_rx_if.sv
// memlcd_rx_if: word-stream bus produced by memlcd_rx.
//
// Handshake: there is no ready. wr_valid is a one-cycle strobe, and the
// consumer must take wr_line/wr_idx/wr_data in that cycle. The fields then
// hold until the next strobe. line_done and frame_done are one-cycle pulses
// on the same bus.
//
// Signals:
//   wr_valid    word strobe
//   wr_line     line address of the word
//   wr_idx      word index within the line
//   wr_data     pixel word, first-received bit in bit 0
//   line_done   pulse after a line's dummy bits
//   frame_done  pulse on a clean chip-select deassert
//
// Modports: master (receiver side, drives the bus), slave (consumer side).
interface memlcd_rx_if #(
  parameter int ADDR_BITS = 10,
  parameter int LINE_BITS = 336,
  parameter int WORD_W    = 16
);
  localparam int WORDS = LINE_BITS / WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic                 wr_valid;
  logic [ADDR_BITS-1:0] wr_line;
  logic [IDX_W-1:0]     wr_idx;
  logic [WORD_W-1:0]    wr_data;
  logic                 line_done;
  logic                 frame_done;

  modport master (
    output wr_valid, wr_line, wr_idx, wr_data, line_done, frame_done
  );

  modport slave (
    input wr_valid, wr_line, wr_idx, wr_data, line_done, frame_done
  );
endinterface

// File: rtl/memlcd_rx.sv
// memlcd_rx: receiver for the memory-LCD serial link (lcd_sclk/lcd_si/lcd_scs).
//
// The three link lines are oversampled on clk. The receiver decodes the
// mode / address / data / dummy framing and emits each line as a stream of
// WORD_W-bit pixel words tagged with the line address and word index.
//
// Ports:
//   clk, rst_n  system clock (>= 4x lcd_sclk) and async active-low reset
//   lcd_sclk    serial clock, asynchronous to clk
//   lcd_si      serial data, taken at lcd_sclk rising edges
//   lcd_scs     chip select, active high
//   mode        mode field of the current/last frame
//   wr          word-stream bus (memlcd_rx_if.master)
//   err_trunc   sticky; scs fell mid-field, cleared by the next scs rise
//   frame_sum   frame checksum, or 0 when the checksum is not built
//   dbg_state   current FSM state
//
// Build option: define MEMLCD_RX_CHECKSUM_EN to build the frame checksum.
// The checksum is frame_sum <- rotl(frame_sum,1) ^ {line, idx, data},
// updated on every word. Without the macro, frame_sum is tied to 0.
//
// Latency: a strobe or pulse appears 4 clk after the lcd_sclk rise or
// lcd_scs fall that causes it. The stages are 2 sync, 1 edge register and
// 1 output register.
module memlcd_rx #(
  parameter int MODE_BITS  = 6,
  parameter int ADDR_BITS  = 10,
  parameter int LINE_BITS  = 336,
  parameter int DUMMY_BITS = 6,
  parameter int WORD_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lcd_sclk,
  input  logic                 lcd_si,
  input  logic                 lcd_scs,
  output logic [MODE_BITS-1:0] mode,
  memlcd_rx_if.master          wr,
  output logic                 err_trunc,
  output logic [31:0]          frame_sum,
  output logic [2:0]           dbg_state
);
  localparam int WORDS  = LINE_BITS / WORD_W;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int MAX_AM = (MODE_BITS > ADDR_BITS) ? MODE_BITS : ADDR_BITS;
  localparam int MAX_DW = (DUMMY_BITS > WORD_W) ? DUMMY_BITS : WORD_W;
  localparam int F_MAX  = (MAX_AM > MAX_DW) ? MAX_AM : MAX_DW;
  localparam int CNT_W  = $clog2(F_MAX + 1);
  localparam int SH_W   = (MAX_AM > WORD_W) ? MAX_AM : WORD_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MODE  = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    DUMMY = 3'd4
  } state_t;

  // ---------------- synchronizers and edge detect ----------------
  logic [1:0] sclk_s, si_s, scs_s;
  logic       sclk_d, scs_d;
  logic [1:0] sync_vld;
  logic       armed;
  logic       rise_q, bit_q, srise_q, sfall_q;

  // armed holds off scs-rise detection until scs has been seen low after
  // reset. A frame interrupted by reset is then dropped, not re-entered
  // mid-stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s   <= '0;
      si_s     <= '0;
      scs_s    <= '0;
      sclk_d   <= 1'b0;
      scs_d    <= 1'b0;
      sync_vld <= '0;
      armed    <= 1'b0;
      rise_q   <= 1'b0;
      bit_q    <= 1'b0;
      srise_q  <= 1'b0;
      sfall_q  <= 1'b0;
    end else begin
      sclk_s   <= {sclk_s[0], lcd_sclk};
      si_s     <= {si_s[0], lcd_si};
      scs_s    <= {scs_s[0], lcd_scs};
      sclk_d   <= sclk_s[1];
      scs_d    <= scs_s[1];
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && !scs_s[1]) armed <= 1'b1;
      rise_q   <= sclk_s[1] & ~sclk_d & scs_s[1];
      bit_q    <= si_s[1];
      srise_q  <= armed & scs_s[1] & ~scs_d;
      sfall_q  <= ~scs_s[1] & scs_d;
    end
  end

  // ---------------- FSM ----------------
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   word_idx;
  logic [SH_W-2:0]    sh;
  logic [SH_W-1:0]    sh_next;

  logic               start, shift_en, field_end, emit_word, line_last;
  logic               line_end, clean_end, trunc;
  logic [CNT_W-1:0]   last_cnt;

  assign dbg_state = state_q;
  // Fields arrive LSB-first, so each new bit enters at the top. After N
  // bits the field occupies the top N bits of sh_next.
  assign sh_next   = {bit_q, sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (srise_q) state_d = MODE;
    end else if (sfall_q) begin
      state_d = IDLE;
    end else if (field_end) begin
      case (state_q)
        MODE:    state_d = ADDR;
        ADDR:    state_d = DATA;
        DATA:    state_d = line_last ? DUMMY : DATA;
        DUMMY:   state_d = ADDR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    last_cnt = '0;
    case (state_q)
      MODE:    last_cnt = CNT_W'(MODE_BITS - 1);
      ADDR:    last_cnt = CNT_W'(ADDR_BITS - 1);
      DATA:    last_cnt = CNT_W'(WORD_W - 1);
      DUMMY:   last_cnt = CNT_W'(DUMMY_BITS - 1);
      default: last_cnt = '0;
    endcase
    start     = (state_q == IDLE) && srise_q;
    shift_en  = rise_q && !sfall_q && (state_q != IDLE);
    field_end = shift_en && (bit_cnt == last_cnt);
    emit_word = field_end && (state_q == DATA);
    line_last = emit_word && (word_idx == IDX_W'(WORDS - 1));
    line_end  = field_end && (state_q == DUMMY);
    // A frame ends cleanly only on a line boundary: either before any
    // address bit, or right after the trailer.
    clean_end = sfall_q && (state_q == ADDR) &&
                ((bit_cnt == '0) || (bit_cnt == CNT_W'(DUMMY_BITS)));
    trunc     = sfall_q && (state_q != IDLE) && !clean_end;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh            <= '0;
      bit_cnt       <= '0;
      word_idx      <= '0;
      mode          <= '0;
      err_trunc     <= 1'b0;
      wr.wr_valid   <= 1'b0;
      wr.wr_line    <= '0;
      wr.wr_idx     <= '0;
      wr.wr_data    <= '0;
      wr.line_done  <= 1'b0;
      wr.frame_done <= 1'b0;
    end else begin
      wr.wr_valid   <= emit_word;
      wr.line_done  <= line_end;
      wr.frame_done <= clean_end;
      if (start) begin
        bit_cnt   <= '0;
        word_idx  <= '0;
        err_trunc <= 1'b0;
      end else begin
        if (trunc) err_trunc <= 1'b1;
        if (shift_en) begin
          sh      <= sh_next[SH_W-1:1];
          bit_cnt <= field_end ? '0 : bit_cnt + 1'b1;
          if (field_end && (state_q == MODE))
            mode <= sh_next[SH_W-1 -: MODE_BITS];
          if (field_end && (state_q == ADDR)) begin
            wr.wr_line <= sh_next[SH_W-1 -: ADDR_BITS];
            word_idx   <= '0;
          end
          if (emit_word) begin
            wr.wr_data <= sh_next[SH_W-1 -: WORD_W];
            wr.wr_idx  <= word_idx;
            word_idx   <= word_idx + 1'b1;
          end
        end
      end
    end
  end

`ifdef MEMLCD_RX_CHECKSUM_EN
  // wr_line already holds the current line when a word completes.
  logic [ADDR_BITS+IDX_W+WORD_W-1:0] sum_src;
  assign sum_src = {wr.wr_line, word_idx, sh_next[SH_W-1 -: WORD_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sum <= '0;
    end else if (start) begin
      frame_sum <= '0;
    end else if (emit_word) begin
      frame_sum <= {frame_sum[30:0], frame_sum[31]} ^ 32'(sum_src);
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_memlcd_rx.sv
module tb_memlcd_rx;
  localparam int MODE_BITS  = 6;
  localparam int ADDR_BITS  = 10;
  localparam int LINE_BITS  = 336;
  localparam int DUMMY_BITS = 6;
  localparam int WORD_W     = 16;
  localparam int WORDS      = 21;
  localparam int IDX_W      = 5;
  localparam int SB_W       = ADDR_BITS + IDX_W + WORD_W;

  // ---------------- clock / reset ----------------
  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic lcd_sclk = 1'b0;
  logic lcd_si   = 1'b0;
  logic lcd_scs  = 1'b0;

  logic [MODE_BITS-1:0] mode;
  logic                 err_trunc;
  logic [31:0]          frame_sum;
  logic [2:0]           dbg_state;

  always #5 clk = ~clk;

  memlcd_rx_if #(.ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS), .WORD_W(WORD_W)) wr_if ();

  memlcd_rx #(
    .MODE_BITS(MODE_BITS), .ADDR_BITS(ADDR_BITS), .LINE_BITS(LINE_BITS),
    .DUMMY_BITS(DUMMY_BITS), .WORD_W(WORD_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lcd_sclk  (lcd_sclk),
    .lcd_si    (lcd_si),
    .lcd_scs   (lcd_scs),
    .mode      (mode),
    .wr        (wr_if),
    .err_trunc (err_trunc),
    .frame_sum (frame_sum),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_line   = 0;
  int n_frame  = 0;
  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] mon_e;
  logic [31:0]     exp_sum = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (wr_if.wr_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("word", 64'({wr_if.wr_line, wr_if.wr_idx, wr_if.wr_data}), 64'(mon_e));
      end
    end
    if (wr_if.line_done)  n_line++;
    if (wr_if.frame_done) n_frame++;
  end

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  function automatic logic [31:0] sum_exp();
`ifdef MEMLCD_RX_CHECKSUM_EN
    return exp_sum;
`else
    return 32'd0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Every input edge lands 1 time unit after a clk negedge plus a multiple
  // of 10, so it never coincides with a posedge. The sclk period is 8 clk.
  task automatic send_bit(input logic b);
    lcd_si = b;
    #40 lcd_sclk = 1'b1;
    #40 lcd_sclk = 1'b0;
  endtask

  task automatic send_lsb(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic scs_up();
    @(negedge clk);
    #1 lcd_scs = 1'b1;
    exp_sum = '0;
    #80;
  endtask

  task automatic scs_down(input logic clean);
    int lat;
    lat = 0;
    @(negedge clk);
    #1 lcd_scs = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (wr_if.frame_done && lat == 0) lat = i;
    end
    if (clean) chk("frame_done_latency", 64'(lat), 64'd4);
  endtask

  // Address goes LSB-first. Pixel words go MSB-first on the wire, so the
  // receiver's wr_data (first bit in bit 0) is the bit-reverse. Only words
  // fully sent before `limit` data bits are expected.
  task automatic send_line(input logic [9:0] addr, input logic [15:0] word, input int limit);
    logic [SB_W-1:0] e;
    send_lsb(16'(addr), ADDR_BITS);
    for (int w = 0; w < WORDS; w++) begin
      if ((w + 1) * WORD_W <= limit) begin
        e = {addr, 5'(w), rev16(word)};
        exp_q.push_back(e);
        exp_sum = {exp_sum[30:0], exp_sum[31]} ^ 32'(e);
      end
    end
    for (int b = 0; b < limit && b < LINE_BITS; b++) send_bit(word[15 - (b % 16)]);
    if (limit >= LINE_BITS) send_lsb(16'd0, DUMMY_BITS);
  endtask

  // ---------------- directed sequence ----------------
  int v0, l0, f0;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_valid",   64'(wr_if.wr_valid),   64'd0);
    chk("rst_wr_line",    64'(wr_if.wr_line),    64'd0);
    chk("rst_wr_idx",     64'(wr_if.wr_idx),     64'd0);
    chk("rst_wr_data",    64'(wr_if.wr_data),    64'd0);
    chk("rst_line_done",  64'(wr_if.line_done),  64'd0);
    chk("rst_frame_done", 64'(wr_if.frame_done), 64'd0);
    chk("rst_mode",       64'(mode),             64'd0);
    chk("rst_err_trunc",  64'(err_trunc),        64'd0);
    chk("rst_frame_sum",  64'(frame_sum),        64'd0);
    chk("rst_state",      64'(dbg_state),        64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single line, addr 5, 0xAAAA words.
    v0 = n_valid; l0 = n_line; f0 = n_frame;
    scs_up();
    send_lsb(16'b000001, MODE_BITS);
    send_line(10'd5, 16'hAAAA, LINE_BITS);
    send_lsb(16'd0, DUMMY_BITS);
    scs_down(1'b1);
    chk("t1_valid_count", 64'(n_valid - v0), 64'd21);
    chk("t1_line_done",   64'(n_line - l0),  64'd1);
    chk("t1_frame_done",  64'(n_frame - f0), 64'd1);
    chk("t1_err_trunc",   64'(err_trunc),    64'd0);
    chk("t1_mode",        64'(mode),         64'd1);
    chk("t1_last_line",   64'(wr_if.wr_line), 64'd5);
    chk("t1_last_idx",    64'(wr_if.wr_idx),  64'd20);
    chk("t1_last_data",   64'(wr_if.wr_data), 64'h5555);
    chk("t1_exp_empty",   64'(exp_q.size()), 64'd0);
    chk("t1_frame_sum",   64'(frame_sum),    64'(sum_exp()));

    // Three consecutive lines.
    v0 = n_valid; l0 = n_line; f0 = n_frame;
    scs_up();
    send_lsb(16'b000001, MODE_BITS);
    send_line(10'd0,   16'h1234, LINE_BITS);
    send_line(10'd1,   16'hF00F, LINE_BITS);
    send_line(10'd535, 16'h8001, LINE_BITS);
    send_lsb(16'd0, DUMMY_BITS);
    scs_down(1'b1);
    chk("t2_valid_count", 64'(n_valid - v0), 64'd63);
    chk("t2_line_done",   64'(n_line - l0),  64'd3);
    chk("t2_frame_done",  64'(n_frame - f0), 64'd1);
    chk("t2_last_line",   64'(wr_if.wr_line), 64'd535);
    chk("t2_exp_empty",   64'(exp_q.size()), 64'd0);
    chk("t2_frame_sum",   64'(frame_sum),    64'(sum_exp()));

    // All-clear frame: mode then trailer only.
    v0 = n_valid; l0 = n_line; f0 = n_frame;
    scs_up();
    send_lsb(16'b000100, MODE_BITS);
    send_lsb(16'd0, DUMMY_BITS);
    scs_down(1'b1);
    chk("t3_valid_count", 64'(n_valid - v0), 64'd0);
    chk("t3_frame_done",  64'(n_frame - f0), 64'd1);
    chk("t3_mode",        64'(mode),         64'd4);
    chk("t3_err_trunc",   64'(err_trunc),    64'd0);

    // scs dropped after 100 data bits.
    v0 = n_valid; l0 = n_line; f0 = n_frame;
    scs_up();
    send_lsb(16'b000001, MODE_BITS);
    send_line(10'd7, 16'h00FF, 100);
    scs_down(1'b0);
    chk("t4_valid_count", 64'(n_valid - v0), 64'd6);
    chk("t4_err_trunc",   64'(err_trunc),    64'd1);
    chk("t4_frame_done",  64'(n_frame - f0), 64'd0);
    chk("t4_line_done",   64'(n_line - l0),  64'd0);
    chk("t4_exp_empty",   64'(exp_q.size()), 64'd0);
    v0 = n_valid; f0 = n_frame;
    scs_up();
    chk("t4_err_cleared", 64'(err_trunc), 64'd0);
    send_lsb(16'b000001, MODE_BITS);
    send_line(10'd9, 16'hC3A5, LINE_BITS);
    send_lsb(16'd0, DUMMY_BITS);
    scs_down(1'b1);
    chk("t4r_valid_count", 64'(n_valid - v0), 64'd21);
    chk("t4r_frame_done",  64'(n_frame - f0), 64'd1);
    chk("t4r_err_trunc",   64'(err_trunc),    64'd0);
    chk("t4r_last_line",   64'(wr_if.wr_line), 64'd9);

    // Reset at data bit 50, scs left high; the rest of the frame is ignored.
    scs_up();
    send_lsb(16'b000001, MODE_BITS);
    send_line(10'd3, 16'h0F0F, 50);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_wr_valid",  64'(wr_if.wr_valid), 64'd0);
    chk("t5_rst_wr_line",   64'(wr_if.wr_line),  64'd0);
    chk("t5_rst_wr_idx",    64'(wr_if.wr_idx),   64'd0);
    chk("t5_rst_wr_data",   64'(wr_if.wr_data),  64'd0);
    chk("t5_rst_mode",      64'(mode),           64'd0);
    chk("t5_rst_state",     64'(dbg_state),      64'd0);
    chk("t5_rst_frame_sum", 64'(frame_sum),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid; l0 = n_line; f0 = n_frame;
    send_lsb(16'hFFFF, 16);
    send_lsb(16'hFFFF, 16);
    scs_down(1'b0);
    chk("t5_valid_count", 64'(n_valid - v0), 64'd0);
    chk("t5_line_done",   64'(n_line - l0),  64'd0);
    chk("t5_frame_done",  64'(n_frame - f0), 64'd0);
    chk("t5_err_trunc",   64'(err_trunc),    64'd0);
    chk("t5_state_idle",  64'(dbg_state),    64'd0);
    chk("t5_exp_empty",   64'(exp_q.size()), 64'd0);
    v0 = n_valid; f0 = n_frame;
    scs_up();
    send_lsb(16'b000011, MODE_BITS);
    send_line(10'd12, 16'h1357, LINE_BITS);
    send_lsb(16'd0, DUMMY_BITS);
    scs_down(1'b1);
    chk("t5r_valid_count", 64'(n_valid - v0), 64'd21);
    chk("t5r_frame_done",  64'(n_frame - f0), 64'd1);
    chk("t5r_mode",        64'(mode),         64'd3);
    chk("t5r_last_line",   64'(wr_if.wr_line), 64'd12);

    // Checksum: addr 0, all 0xFFFF; value must hold after frame_done.
    scs_up();
    send_lsb(16'b000001, MODE_BITS);
    send_line(10'd0, 16'hFFFF, LINE_BITS);
    send_lsb(16'd0, DUMMY_BITS);
    scs_down(1'b1);
    chk("t6_frame_sum", 64'(frame_sum), 64'(sum_exp()));
    repeat (20) @(negedge clk);
    chk("t6_frame_sum_hold", 64'(frame_sum), 64'(sum_exp()));
    chk("t6_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    chk("watchdog_timeout", 64'd0, 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memlcd_rx.md
# memlcd_rx

Synthesizable receiver for the memory-LCD serial link (lcd_sclk / lcd_si / lcd_scs). It sits directly downstream of the memlcd serializer in the simulation bench. It oversamples the three lines on the system clock, decodes the mode/address/data/dummy framing, and emits each line as a stream of pixel words with its line address. Benches use it as a scoreboard front-end in place of waveform-level checks on sclk/si/scs.

## Interface
- MODE_BITS, 6: mode field width; bit 0 = update, bit 1 = VCOM, bit 2 = all-clear.
- ADDR_BITS, 10: line address width.
- LINE_BITS, 336: pixel bits per line; must be a multiple of WORD_W.
- DUMMY_BITS, 6: dummy bits after each line, and the trailer length.
- WORD_W, 16: output word width.
- clk  in  1  system clock; must run ≥4× the lcd_sclk frequency.
- rst_n  in  1  asynchronous active-low reset.
- lcd_sclk  in  1  serial clock; asynchronous to clk.
- lcd_si  in  1  serial data; sampled on lcd_sclk rising edge.
- lcd_scs  in  1  chip select, active high.
- mode  out  MODE_BITS  mode field of the current/last frame.
- wr_valid  out  1  one-cycle strobe; the word fields are valid.
- wr_line  out  ADDR_BITS  line address of the word.
- wr_idx  out  clog2(LINE_BITS/WORD_W)  word index within the line.
- wr_data  out  WORD_W  pixels; first-received bit in bit 0.
- line_done  out  1  one-cycle pulse after the line's dummy bits complete.
- frame_done  out  1  one-cycle pulse on a clean scs deassert.
- err_trunc  out  1  sticky; scs fell mid-field. Cleared by the next scs rise.
- frame_sum  out  32  frame checksum (see Configuration).

## Operation
- lcd_sclk, lcd_si and lcd_scs each pass through a 2-FF synchronizer.
- Rising edge of lcd_sclk = synchronized sclk 1 now, 0 on the previous cycle.
- Bits are shifted only while synchronized scs = 1. Edges while scs = 0 are ignored.
- FSM states: IDLE, MODE, ADDR, DATA, DUMMY.
  - IDLE → MODE on scs rise. The same transition clears bit counters and err_trunc.
  - MODE → ADDR after MODE_BITS bits; mode is updated.
  - ADDR → DATA after ADDR_BITS bits. Address is LSB-first and latched into wr_line.
  - DATA: every WORD_W bits, strobe wr_valid; wr_idx increments from 0. After LINE_BITS bits go to DUMMY.
  - DUMMY → ADDR after DUMMY_BITS bits, pulsing line_done.
- scs fall behaviour:
  - In ADDR with 0 or DUMMY_BITS bits shifted: clean end (covers the trailer and all-clear frames). Pulse frame_done, go to IDLE.
  - Any other state or count: set err_trunc, go to IDLE, no frame_done. A partial word is not emitted.
- Dummy and trailer bit values are not checked.
- Bits beyond ADDR_BITS while in ADDR cannot occur, because the FSM moves to DATA at exactly ADDR_BITS bits.
- scs rise while not IDLE cannot occur, because scs must fall first. A synchronizer glitch shorter than one clk is not filtered.

## Timing
- Reset values: all outputs 0; FSM = IDLE; counters 0.
- rst_n asserted mid-frame: immediate return to IDLE; no pulses. The frame in progress is dropped and only re-acquired on the next scs rise.
- Latency:
  - wr_valid is asserted 4 clk after the lcd_sclk rising edge of the word's last bit (2 sync + 1 edge detect + 1 register).
  - line_done has the same latency, relative to the last dummy bit.
  - frame_done: 4 clk after the lcd_scs fall.
- No backpressure. wr_* fields hold until the next strobe.
- Minimum spacing between wr_valid strobes is WORD_W sclk periods.

## Configuration
- MEMLCD_RX_CHECKSUM_EN defined:
  - frame_sum is cleared at frame start.
  - On each wr_valid: frame_sum ← rotl(frame_sum, 1) ^ {wr_line, wr_idx, wr_data} (zero-extended/truncated to 32 bits).
  - frame_sum is stable from frame_done until the next scs rise.
- Undefined: frame_sum tied to 0 and no checksum logic is built.

## Test plan
- Single line, default params:
  - Stimulus: mode 6'b000001, addr 10'd5, data alternating 0xAAAA words, 6 dummy bits, 6-bit trailer.
  - Response: exactly 21 wr_valid, wr_line = 5, wr_idx 0..20, wr_data = 16'h5555 (LSB-first); 1 line_done; 1 frame_done; err_trunc = 0.
- Three consecutive lines (addr 0, 1, 535):
  - Response: 63 wr_valid, 3 line_done, wr_line sequence 0/1/535.
- All-clear frame:
  - Stimulus: mode 6'b000100 followed by 6 trailer bits.
  - Response: 0 wr_valid, 1 frame_done, mode = 4.
- scs dropped after 100 data bits:
  - Response: 6 wr_valid, err_trunc = 1, no frame_done. The next clean frame clears err_trunc and completes normally.
- Reset mid-DATA:
  - Stimulus: rst_n low for 2 clk at bit 50.
  - Response: all outputs 0 with no pulses. The following frame decodes correctly.
- Checksum (macro on):
  - Stimulus: single line, addr 0, all data 0xFFFF.
  - Response: frame_sum matches the bench model's fold of 21 words.
  - Macro off: frame_sum = 0.
